// File: rtl/multdiv_sched.sv
// Sequences the multi-cycle multiply/divide unit: accepts mult/div from DX, starts the unit,
// freezes the front end while in flight and writes the result or rstatus code back.
module multdiv_sched #(
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned MULT_CODE  = 4,
    parameter int unsigned DIV_CODE   = 5,
    parameter int unsigned STATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrDX,
    input  logic        validDX,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [31:0] mdResult,
    input  logic        mdException,
    input  logic        mdReady,
    input  logic        mwWriteReg,
    output logic [31:0] mdA,
    output logic [31:0] mdB,
    output logic        ctrlMult,
    output logic        ctrlDiv,
    output logic        stall,
    output logic        insertNop,
    output logic        wbEnable,
    output logic [4:0]  wbAddr,
    output logic [31:0] wbData,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned REG_W = 5;
    localparam int unsigned DAT_W = 32;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_WB} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DAT_W-1:0]   mda_q, mda_d, mdb_q, mdb_d, res_q, res_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic               div_q, div_d, exc_q, exc_d;
    logic               is_md_c;
    logic               unused_instr;

    assign is_md_c = validDX && (instrDX[31:27] == 5'b00000)
                     && ((instrDX[6:2] == 5'b00110) || (instrDX[6:2] == 5'b00111));
    assign unused_instr = ^{instrDX[21:7], instrDX[1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mda_q   <= '0;
            mdb_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            div_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mda_q   <= mda_d;
            mdb_q   <= mdb_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            div_q   <= div_d;
            exc_q   <= exc_d;
        end
    end

    // Next-state and strobe decode; the writeback strobe must see mwWriteReg in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mda_d    = mda_q;
        mdb_d    = mdb_q;
        res_d    = res_q;
        rd_d     = rd_q;
        div_d    = div_q;
        exc_d    = exc_q;
        ctrlMult = 1'b0;
        ctrlDiv  = 1'b0;
        wbEnable = 1'b0;
        wbAddr   = '0;
        wbData   = '0;
        case (state_q)
            S_IDLE: begin
                if (is_md_c) begin
                    mda_d   = dataA;
                    mdb_d   = dataB;
                    rd_d    = instrDX[26:22];
                    div_d   = (instrDX[6:2] == 5'b00111);
                    exc_d   = 1'b0;
                    res_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                ctrlMult = !div_q;
                ctrlDiv  = div_q;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != CNT_W'(TIMEOUT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A result arriving on the timeout cycle takes priority over the abort.
                if (mdReady) begin
                    res_d   = mdResult;
                    exc_d   = mdException;
                    state_d = S_WB;
                end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    exc_d   = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (!mwWriteReg) begin
                    state_d = S_IDLE;
                    if (exc_q) begin
                        wbEnable = 1'b1;
                        wbAddr   = REG_W'(STATUS_REG);
                        wbData   = div_q ? DAT_W'(DIV_CODE) : DAT_W'(MULT_CODE);
                    end else if (rd_q != '0) begin
                        wbEnable = 1'b1;
                        wbAddr   = rd_q;
                        wbData   = res_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mdA       = mda_q;
    assign mdB       = mdb_q;
    assign busy      = (state_q != S_IDLE);
    assign stall     = busy;
    assign insertNop = busy;

endmodule

// File: tb/tb_multdiv_sched.sv
// Transaction-level bench for multdiv_sched: each op's expected writeback is derived from
// the op type, destination, result/exception and ready delay.
module tb_multdiv_sched;

    localparam int unsigned TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instrDX, dataA, dataB, mdResult;
    logic        validDX, mdException, mdReady, mwWriteReg;
    logic [31:0] mdA, mdB, wbData;
    logic [4:0]  wbAddr;
    logic        ctrlMult, ctrlDiv, stall, insertNop, wbEnable, busy;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_sched dut (
        .clock(clock), .reset(reset), .instrDX(instrDX), .validDX(validDX),
        .dataA(dataA), .dataB(dataB), .mdResult(mdResult), .mdException(mdException),
        .mdReady(mdReady), .mwWriteReg(mwWriteReg), .mdA(mdA), .mdB(mdB),
        .ctrlMult(ctrlMult), .ctrlDiv(ctrlDiv), .stall(stall), .insertNop(insertNop),
        .wbEnable(wbEnable), .wbAddr(wbAddr), .wbData(wbData), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input logic is_div, input logic [4:0] rd);
        logic [14:0] mid = 15'($urandom);
        logic [1:0]  lo  = 2'($urandom);
        return {5'b00000, rd, mid, (is_div ? 5'b00111 : 5'b00110), lo};
    endfunction

    task automatic drive_idle();
        validDX = 1'b0; instrDX = $urandom; dataA = $urandom; dataB = $urandom;
        mdReady = 1'b0; mdException = 1'b0; mdResult = $urandom; mwWriteReg = 1'b0;
    endtask

    // One full operation; delay >= TIMEOUT means the unit never answers.
    task automatic run_op(input logic is_div, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input int delay, input logic exc,
                          input logic [31:0] res, input int hold);
        logic        exc_eff;
        logic        exp_en;
        logic [31:0] exp_addr, exp_data;
        exc_eff  = (delay >= int'(TIMEOUT)) || exc;
        exp_en   = exc_eff || (rd != 5'd0);
        exp_addr = exc_eff ? 32'd30 : 32'(rd);
        exp_data = exc_eff ? (is_div ? 32'd5 : 32'd4) : res;

        @(negedge clock);
        drive_idle();
        validDX = 1'b1; instrDX = encode(is_div, rd); dataA = a; dataB = b;
        #1;
        check("accept_stall", 32'(stall), 32'd0);

        @(negedge clock);
        drive_idle();
        #1;
        check("start_stall", 32'(stall), 32'd1);
        check("start_ctrlMult", 32'(ctrlMult), 32'(!is_div));
        check("start_ctrlDiv", 32'(ctrlDiv), 32'(is_div));
        check("start_mdA", mdA, a);
        check("start_mdB", mdB, b);

        @(negedge clock);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            drive_idle();
            #1;
            check("wait_stall", 32'(stall), 32'd1);
            check("wait_ctrl", 32'({ctrlMult, ctrlDiv}), 32'd0);
            check("wait_wbEnable", 32'(wbEnable), 32'd0);
            if (i == delay) begin
                mdReady = 1'b1; mdResult = res; mdException = exc;
            end
            @(negedge clock);
            if (i == delay) break;
        end

        for (int j = 0; j < hold; j++) begin
            drive_idle();
            mwWriteReg = 1'b1;
            mdReady = 1'($urandom_range(0, 1));
            #1;
            check("hold_wbEnable", 32'(wbEnable), 32'd0);
            check("hold_stall", 32'(insertNop), 32'd1);
            @(negedge clock);
        end

        drive_idle();
        #1;
        check("wb_enable", 32'(wbEnable), 32'(exp_en));
        check("wb_busy", 32'(busy), 32'd1);
        if (exp_en) begin
            check("wb_addr", 32'(wbAddr), exp_addr);
            check("wb_data", wbData, exp_data);
        end

        @(negedge clock);
        #1;
        check("post_stall", 32'(stall), 32'd0);
        check("post_wbEnable", 32'(wbEnable), 32'd0);
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mdA", mdA, 32'd0);
        check("rst_wbData", wbData, 32'd0);
        reset = 1'b1;

        run_op(1'b0, 5'd5, 32'd7, 32'd6, 3, 1'b0, 32'd42, 0);
        run_op(1'b1, 5'd9, 32'd10, 32'd0, 1, 1'b1, 32'hdead, 0);
        run_op(1'b0, 5'd12, 32'd3, 32'd4, 0, 1'b0, 32'd12, 2);
        run_op(1'b0, 5'd7, 32'd1, 32'd2, 1000, 1'b0, 32'd0, 0);
        run_op(1'b1, 5'd7, 32'd1, 32'd2, 1000, 1'b0, 32'd0, 1);
        run_op(1'b0, 5'd0, 32'd8, 32'd8, 2, 1'b0, 32'd64, 0);
        run_op(1'b1, 5'd3, 32'd9, 32'd3, int'(TIMEOUT) - 1, 1'b0, 32'd3, 0);

        // Bubble with a mult encoding and a non-mult/div instruction must not start anything.
        @(negedge clock);
        drive_idle();
        instrDX = encode(1'b0, 5'd4);
        @(negedge clock);
        drive_idle();
        instrDX = {5'b00000, 5'd4, 15'd0, 5'b00101, 2'b00};
        validDX = 1'b1;
        #1;
        check("bubble_stall", 32'(stall), 32'd0);
        check("bubble_ctrl", 32'(ctrlMult), 32'd0);
        @(negedge clock);
        drive_idle();
        #1;
        check("nonmd_stall", 32'(stall), 32'd0);
        check("nonmd_ctrl", 32'({ctrlMult, ctrlDiv}), 32'd0);

        // Reset asserted mid-WAIT, then a stray ready pulse.
        @(negedge clock);
        validDX = 1'b1; instrDX = encode(1'b1, 5'd6); dataA = 32'd77; dataB = 32'd11;
        repeat (4) @(negedge clock);
        drive_idle();
        reset = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_mdA", mdA, 32'd0);
        check("midrst_mdB", mdB, 32'd0);
        check("midrst_wbAddr", 32'(wbAddr), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        mdReady = 1'b1; mdResult = 32'd99;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("midrst_idle_stall", 32'(stall), 32'd0);
            check("midrst_idle_ctrl", 32'({ctrlMult, ctrlDiv}), 32'd0);
            check("midrst_idle_wb", 32'(wbEnable), 32'd0);
            @(negedge clock);
            mdReady = 1'b0;
        end

        for (int t = 0; t < 40; t++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 9));
            run_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                   d, ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_sched.md
Name: multdiv_sched

Overview:
- Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline.
- Detects mult/div in the DX stage, latches the operands and the destination register, and pulses the unit's start control.
- Freezes the front end while the operation is in flight.
- Writes the result, or the rstatus exception code, through the register-file write port once the MW stage is not using that port. MW-stage writeReg never covers mult/div, so this block is their only writeback path.

Parameters:
TIMEOUT, 64, maximum WAIT cycles before the operation is aborted as an exception
MULT_CODE, 4, value written to rstatus on a mult exception or timeout
DIV_CODE, 5, value written to rstatus on a div exception or timeout
STATUS_REG, 30, register index of rstatus

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instrDX  in  32  instruction in DX latch
validDX  in  1  DX latch holds a real instruction (not a bubble)
dataA  in  32  DX operand rs
dataB  in  32  DX operand rt
mdResult  in  32  multdiv result
mdException  in  1  multdiv overflow / divide-by-zero, valid with mdReady
mdReady  in  1  multdiv result valid (1-cycle pulse)
mwWriteReg  in  1  MW stage is using the register-file write port this cycle
mdA  out  32  latched operand A to multdiv
mdB  out  32  latched operand B to multdiv
ctrlMult  out  1  1-cycle start pulse, multiply
ctrlDiv  out  1  1-cycle start pulse, divide
stall  out  1  freeze PC, FD and DX latches
insertNop  out  1  load bubble into XM latch
wbEnable  out  1  register write strobe (1 cycle)
wbAddr  out  5  register write index
wbData  out  32  register write data
busy  out  1  operation in flight

Behaviour:
- Decode: isMD = validDX && opcode instrDX[31:27]==00000 && ALU op instrDX[6:2] is 00110 (mult) or 00111 (div). Destination rd = instrDX[26:22].
- Reset (async, reset==0):
  - State goes to IDLE and the counter clears.
  - Every output is 0, including mdA/mdB, wbAddr and wbData.
  - All latched fields clear.
- States: IDLE, START, WAIT, WB.
- IDLE:
  - stall=0 and busy=0.
  - When isMD is true, latch mdA=dataA, mdB=dataB, rd and the op type, then go to START.
  - The mult/div instruction itself leaves DX normally. No stall is applied in the accept cycle.
- START:
  - Assert ctrlMult or ctrlDiv for exactly this cycle, according to the op type.
  - Clear the counter and go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - mdReady: latch mdResult and mdException, then go to WB.
  - Counter reaches TIMEOUT-1 without mdReady: set the latched exception, go to WB.
  - mdReady arriving in the same cycle as the timeout: mdReady wins.
- WB:
  - If mwWriteReg==1, hold in WB with no write.
  - Otherwise, for one cycle assert wbEnable with this address and data, then go to IDLE:
    - Exception: wbAddr=STATUS_REG, wbData=MULT_CODE or DIV_CODE by op type.
    - No exception: wbAddr=rd, wbData=result.
  - When rd==0 and there is no exception, wbEnable stays 0 and the block still returns to IDLE.
- stall = insertNop = busy = (state != IDLE). These outputs are Moore outputs and registered-state-derived only.
- isMD while not IDLE: ignored. It cannot occur legally because DX is frozen.
- mdReady while in IDLE, START or WB: ignored.
- The block does no operand arithmetic. Widths are passed through unchanged. The counter is wide enough for TIMEOUT and saturates without wrapping.
- Minimum occupancy: accept, START, WAIT (1 cycle), WB gives 3 cycles of stall after the accept cycle.

Test Plan:
- Reset low mid-WAIT, then mdReady pulses → state IDLE, stall=0, no ctrl pulse, no wbEnable.
- mult with rd=5, dataA=7, dataB=6; mdReady with result=42 at WAIT cycle 3 → ctrlMult pulses once, mdA=7, mdB=6, stall held until the write, then one wbEnable with wbAddr=5, wbData=42 and a return to IDLE.
- div with dataA=10, dataB=0, mdReady with mdException=1 → wbEnable, wbAddr=30, wbData=5.
- Arrival in WB with mwWriteReg=1 for 2 cycles, then 0 → no write during those 2 cycles, then a single write on the third, with stall high throughout.
- mdReady never asserted → after 64 WAIT cycles, a mult writes wbAddr=30, wbData=4.
- mult with rd=0 → ctrlMult pulses but wbEnable never asserts. Also, validDX=0 with a mult encoding is ignored.
